// File: rtl/ag_ram_phase_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ag_ram_phase_if : CPU byte port and video word port of the Agat RAM |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface ag_ram_phase_if;
    logic [14:0] cpu_adr;
    logic        cpu_cs;
    logic        cpu_read;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_oe;
    logic [13:0] vid_adr;
    logic        vid_re;
    logic [15:0] vid_rdata;

    modport master (
        output cpu_adr, cpu_cs, cpu_read, cpu_wdata, vid_adr, vid_re,
        input  cpu_rdata, cpu_rdata_oe, vid_rdata
    );

    modport slave (
        input  cpu_adr, cpu_cs, cpu_read, cpu_wdata, vid_adr, vid_re,
        output cpu_rdata, cpu_rdata_oe, vid_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ag_ram_phase.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ag_ram_phase : two-phase CPU clock generator and 32 KB dual-view RAM |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ag_ram_phase #(
    parameter int PHI_GAP = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           clk1_in,
    output logic                phi_1,
    output logic                phi_2,
    ag_ram_phase_if.slave       bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GAP_TO_P2 = 3'd1;
    localparam logic [2:0] ST_P2        = 3'd2;
    localparam logic [2:0] ST_GAP_TO_P1 = 3'd3;
    localparam logic [2:0] ST_P1        = 3'd4;

    // Counter starts at PHI_GAP-1 so the phase rises PHI_GAP cycles after the other fell.
    localparam logic [2:0] GAP_LOAD = 3'(PHI_GAP - 1);

    logic       clk1_q;
    logic [2:0] state_q, state_d;
    logic [2:0] gap_cnt_q, gap_cnt_d;
    logic       phi_1_q, phi_1_d;
    logic       phi_2_q, phi_2_d;
    logic [7:0] cpu_rdata_q;
    logic [15:0] vid_rdata_q;
    logic       rise_edge, fall_edge, wr_en;

    logic [7:0] mem_q [0:32767];

    assign rise_edge = clk1_in & ~clk1_q;
    assign fall_edge = ~clk1_in & clk1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk1_q    <= 1'b0;
            state_q   <= ST_IDLE;
            gap_cnt_q <= 3'd0;
            phi_1_q   <= 1'b0;
            phi_2_q   <= 1'b0;
        end else begin
            clk1_q    <= clk1_in;
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            phi_1_q   <= phi_1_d;
            phi_2_q   <= phi_2_d;
        end
    end

    // A fresh clk1_in edge always wins, abandoning any gap still counting.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        if (rise_edge) begin
            state_d   = ST_GAP_TO_P2;
            gap_cnt_d = GAP_LOAD;
        end else if (fall_edge) begin
            state_d   = ST_GAP_TO_P1;
            gap_cnt_d = GAP_LOAD;
        end else begin
            case (state_q)
                ST_GAP_TO_P2: begin
                    if (gap_cnt_q == 3'd0) state_d = ST_P2;
                    else                   gap_cnt_d = gap_cnt_q - 3'd1;
                end
                ST_GAP_TO_P1: begin
                    if (gap_cnt_q == 3'd0) state_d = ST_P1;
                    else                   gap_cnt_d = gap_cnt_q - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        phi_1_d = (state_d == ST_P1);
        phi_2_d = (state_d == ST_P2);
        // Write strobe is the cycle whose edge drops phi_2; never during reset.
        wr_en   = rst_n & phi_2_q & ~phi_2_d & bus.cpu_cs & ~bus.cpu_read;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bus.cpu_adr] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_rdata_q <= 8'h00;
            vid_rdata_q <= 16'h0000;
        end else begin
            cpu_rdata_q <= mem_q[bus.cpu_adr];
            if (bus.vid_re) begin
                vid_rdata_q <= {mem_q[{bus.vid_adr, 1'b1}], mem_q[{bus.vid_adr, 1'b0}]};
            end
        end
    end

    assign phi_1            = phi_1_q;
    assign phi_2            = phi_2_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.cpu_rdata_oe = bus.cpu_cs & bus.cpu_read;
    assign bus.vid_rdata    = vid_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ag_ram_phase.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ag_ram_phase : scoreboard bench for ag_ram_phase (gaps 2 and 4)   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_ag_ram_phase;

    logic clk = 1'b0;
    logic rst_n;
    logic clk1_in;
    logic phi_1, phi_2, phi_1_4, phi_2_4;

    ag_ram_phase_if bus ();
    ag_ram_phase_if bus4 ();

    ag_ram_phase #(.PHI_GAP(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .clk1_in(clk1_in),
        .phi_1(phi_1), .phi_2(phi_2), .bus(bus)
    );

    ag_ram_phase #(.PHI_GAP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clk1_in(clk1_in),
        .phi_1(phi_1_4), .phi_2(phi_2_4), .bus(bus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          due;
        logic [15:0] val;
    } sb_t;

    sb_t         sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    // Reference state: byte array plus "has been written" flags.
    logic [7:0]  mem_m [0:32767];
    bit          known [0:32767];
    int          etype  = 0;
    int          ecyc   = 0;
    bit          prev_c1 = 1'b0;
    bit          exp_p1 [2];
    bit          exp_p2 [2];
    bit          p2_was = 1'b0;
    logic [15:0] vid_exp = 16'h0;
    bit          vid_known = 1'b0;
    logic [14:0] m_a, m_lo, m_hi;
    int          p1_cnt, p2_cnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: samples stimulus at each active edge and queues expectations.
    initial begin
        exp_p1[0] = 1'b0; exp_p1[1] = 1'b0;
        exp_p2[0] = 1'b0; exp_p2[1] = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            m_a = bus.cpu_adr;
            if (!rst_n) begin
                sbq.push_back('{kind: 0, due: cyc, val: 16'h0});
                vid_exp   = 16'h0;
                vid_known = 1'b1;
            end else begin
                if (known[m_a]) sbq.push_back('{kind: 0, due: cyc, val: {8'h0, mem_m[m_a]}});
                if (bus.vid_re) begin
                    m_lo      = {bus.vid_adr, 1'b0};
                    m_hi      = {bus.vid_adr, 1'b1};
                    vid_known = known[m_lo] && known[m_hi];
                    vid_exp   = {mem_m[m_hi], mem_m[m_lo]};
                end
            end
            if (vid_known) sbq.push_back('{kind: 1, due: cyc, val: vid_exp});

            if (!rst_n) begin
                etype   = 0;
                prev_c1 = 1'b0;
            end else begin
                if (clk1_in !== prev_c1) begin
                    etype = clk1_in ? 1 : 2;
                    ecyc  = cyc;
                end
                prev_c1 = clk1_in;
            end
            for (int g = 0; g < 2; g++) begin
                exp_p2[g] = (etype == 1) && (cyc - ecyc >= ((g == 0) ? 2 : 4));
                exp_p1[g] = (etype == 2) && (cyc - ecyc >= ((g == 0) ? 2 : 4));
            end

            if (rst_n && p2_was && !exp_p2[0] && bus.cpu_cs && !bus.cpu_read) begin
                mem_m[m_a] = bus.cpu_wdata;
                known[m_a] = 1'b1;
            end
            p2_was = exp_p2[0];
        end
    end

    // Monitor: compares every registered output against the queued expectations.
    initial begin
        sb_t s;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                s = sbq.pop_front();
                check("sb_due", 16'(s.due), 16'(cyc));
                if (s.kind == 0) check("cpu_rdata", 16'(bus.cpu_rdata), s.val);
                else             check("vid_rdata", bus.vid_rdata, s.val);
            end
            check("phi_1",  16'(phi_1),   16'(exp_p1[0]));
            check("phi_2",  16'(phi_2),   16'(exp_p2[0]));
            check("phi_1_g4", 16'(phi_1_4), 16'(exp_p1[1]));
            check("phi_2_g4", 16'(phi_2_4), 16'(exp_p2[1]));
            check("cpu_rdata_oe", 16'(bus.cpu_rdata_oe), 16'(bus.cpu_cs & bus.cpu_read));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_inputs();
        bus.cpu_cs    = ($urandom_range(0, 3) != 0);
        bus.cpu_read  = 1'($urandom_range(0, 1));
        bus.cpu_adr   = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'(15'h1000 + $urandom_range(0, 63));
        bus.cpu_wdata = 8'($urandom);
        bus.vid_re    = 1'($urandom_range(0, 1));
        bus.vid_adr   = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'(14'h0800 + $urandom_range(0, 31));
    endtask

    task automatic clk1_half(input bit lvl, input int n, input bit rnd);
        clk1_in = lvl;
        for (int i = 0; i < n; i++) begin
            if (rnd) rand_inputs();
            tick();
            p1_cnt += int'(phi_1);
            p2_cnt += int'(phi_2);
        end
    endtask

    task automatic period(input int hi, input int lo, input bit rnd);
        p1_cnt = 0;
        p2_cnt = 0;
        clk1_half(1'b1, hi, rnd);
        clk1_half(1'b0, lo, rnd);
    endtask

    task automatic cpu_cycle(input logic [14:0] adr, input logic [7:0] wd, input bit cs, input bit rd);
        bus.cpu_adr   = adr;
        bus.cpu_wdata = wd;
        bus.cpu_cs    = cs;
        bus.cpu_read  = rd;
        bus.vid_re    = 1'b0;
        period(25, 25, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        clk1_in = 1'b0;
        bus.cpu_adr = '0; bus.cpu_cs = 1'b0; bus.cpu_read = 1'b1; bus.cpu_wdata = '0;
        bus.vid_adr = '0; bus.vid_re = 1'b0;
        bus4.cpu_adr = '0; bus4.cpu_cs = 1'b0; bus4.cpu_read = 1'b1; bus4.cpu_wdata = '0;
        bus4.vid_adr = '0; bus4.vid_re = 1'b0;

        repeat (5) tick();
        check("rst_phi_1", 16'(phi_1), 16'h0);
        check("rst_phi_2", 16'(phi_2), 16'h0);
        check("rst_cpu_rdata", 16'(bus.cpu_rdata), 16'h0);
        check("rst_vid_rdata", bus.vid_rdata, 16'h0);
        rst_n = 1'b1;

        period(25, 25, 1'b0);
        period(25, 25, 1'b0);
        check("phi_2_high_cycles", 16'(p2_cnt), 16'd23);
        check("phi_1_high_cycles", 16'(p1_cnt), 16'd23);

        cpu_cycle(15'h1000, 8'h12, 1'b1, 1'b0);
        cpu_cycle(15'h1001, 8'h34, 1'b1, 1'b0);
        bus.cpu_cs  = 1'b0;
        bus.vid_adr = 14'h0800;
        bus.vid_re  = 1'b1;
        @(posedge clk); #1;
        check("vid_word_0800", bus.vid_rdata, 16'h3412);
        #1;
        bus.vid_re = 1'b0;

        cpu_cycle(15'h1000, 8'hEE, 1'b0, 1'b0);
        check("oe_unselected", 16'(bus.cpu_rdata_oe), 16'h0);
        bus.cpu_cs   = 1'b1;
        bus.cpu_read = 1'b1;
        bus.cpu_adr  = 15'h1000;
        #1;
        check("oe_selected_read", 16'(bus.cpu_rdata_oe), 16'h1);
        @(posedge clk); #1;
        check("cpu_rdata_1000", 16'(bus.cpu_rdata), 16'h0012);
        #1;

        // Collision: write to 0x7FFF while the video port reads word 0x3FFF.
        cpu_cycle(15'h7FFE, 8'h00, 1'b1, 1'b0);
        cpu_cycle(15'h7FFF, 8'h00, 1'b1, 1'b0);
        bus.cpu_adr   = 15'h7FFF;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_cs    = 1'b1;
        bus.cpu_read  = 1'b0;
        bus.vid_adr   = 14'h3FFF;
        bus.vid_re    = 1'b1;
        clk1_half(1'b1, 25, 1'b0);
        clk1_in = 1'b0;
        @(posedge clk); #1;
        check("collision_old", bus.vid_rdata, 16'h0000);
        @(posedge clk); #1;
        check("collision_new", bus.vid_rdata, 16'hA500);
        #1;
        clk1_half(1'b0, 23, 1'b0);
        bus.vid_re = 1'b0;
        bus.cpu_cs = 1'b0;

        for (int r = 0; r < 60; r++) begin
            int hi, lo;
            hi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 25;
            lo = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 25;
            period(hi, lo, 1'b1);
        end
        bus.cpu_cs = 1'b0;
        bus.vid_re = 1'b0;

        // Reset one cycle after a clk1_in rise.
        clk1_half(1'b0, 10, 1'b0);
        clk1_in = 1'b1;
        tick();
        rst_n   = 1'b0;
        clk1_in = 1'b0;
        tick();
        check("midgap_rst_phi_2", 16'(phi_2), 16'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("after_rst_phi_1", 16'(phi_1), 16'h0);
            check("after_rst_phi_2", 16'(phi_2), 16'h0);
        end

        // Short high pulse seen by the PHI_GAP=4 instance.
        period(25, 25, 1'b0);
        clk1_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("short_hi_phi_2_g4", 16'(phi_2_4), 16'h0);
        end
        clk1_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("short_phi_2_g4", 16'(phi_2_4), 16'h0);
            check("short_phi_1_g4", 16'(phi_1_4), 16'(i >= 4));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
